// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = 30 - IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-block, read-only instruction cache: hits are served
// combinationally, misses fetch one word from memory and then hit.
module icache
    import icache_pkg::*;
#(
    parameter int          NUM_SETS = 2 ** IIDX_W,
    parameter logic [31:0] PC_INIT  = 32'h0
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, MISS} state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } frame_t;

    state_t      state_q, state_d;
    logic [31:0] missAddr_q, missAddr_d;
    frame_t      frames_q [NUM_SETS];

    logic [31:0]      reqAddr;
    logic [IDX_W-1:0] reqIdx;
    logic [TAG_W-1:0] reqTag;
    logic [IDX_W-1:0] missIdx;
    logic [TAG_W-1:0] missTag;
    logic             hit;
    logic             fill;
    logic             unusedPcInit;

    assign unusedPcInit = ^PC_INIT;

    assign reqAddr = wordAlign(bus.imemaddr);
    assign reqIdx  = reqAddr[IDX_W+1:2];
    assign reqTag  = reqAddr[31:IDX_W+2];
    assign missIdx = missAddr_q[IDX_W+1:2];
    assign missTag = missAddr_q[31:IDX_W+2];
    assign hit     = frames_q[reqIdx].valid && (frames_q[reqIdx].tag == reqTag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            missAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            missAddr_q <= missAddr_d;
        end
    end

    // Fills overwrite the frame unconditionally, so conflict misses simply evict.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else if (fill) begin
            frames_q[missIdx] <= '{valid: 1'b1, tag: missTag, data: bus.iload};
        end
    end

    always_comb begin
        state_d      = state_q;
        missAddr_d   = missAddr_q;
        fill         = 1'b0;
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        case (state_q)
            IDLE: begin
                if (bus.imemREN) begin
                    if (hit) begin
                        bus.ihit     = 1'b1;
                        bus.imemload = frames_q[reqIdx].data;
                    end else begin
                        missAddr_d = reqAddr;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                // The fetch runs to completion on the latched address even if
                // the datapath has moved on; the request is re-checked in IDLE.
                bus.iREN  = 1'b1;
                bus.iaddr = missAddr_q;
                if (!bus.iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for the instruction cache.
module tb_icache;

    logic CLK;
    logic nRST;
    int   checks;
    int   errors;

    icache_if bus ();

    icache #(.NUM_SETS(16), .PC_INIT(32'h0)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        iwait;
        logic [31:0] iload;
        logic        expHit;
        logic [31:0] expLoad;
        logic        expREN;
        logic [31:0] expAddr;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                                 input logic iwait, input logic [31:0] iload);
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.iwait    = iwait;
        bus.iload    = iload;
    endtask

    task automatic checkOutput(input string name, input logic expHit,
                               input logic [31:0] expLoad, input logic expREN,
                               input logic [31:0] expAddr);
        checks++;
        if (bus.ihit !== expHit) begin
            errors++;
            $display("[TB] FAIL %s ihit got %0b want %0b", name, bus.ihit, expHit);
        end
        checks++;
        if (bus.imemload !== expLoad) begin
            errors++;
            $display("[TB] FAIL %s imemload got %h want %h", name, bus.imemload, expLoad);
        end
        checks++;
        if (bus.iREN !== expREN) begin
            errors++;
            $display("[TB] FAIL %s iREN got %0b want %0b", name, bus.iREN, expREN);
        end
        checks++;
        if (bus.iaddr !== expAddr) begin
            errors++;
            $display("[TB] FAIL %s iaddr got %h want %h", name, bus.iaddr, expAddr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // ren, addr, iwait, iload | hit, load, iREN, iaddr
        vecs[0]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[2]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[3]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[4]  = '{1'b1, 32'h40,  1'b0, 32'h2001_0005, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[5]  = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h43,  1'b1, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h80,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h80,  1'b0, 32'hAAAA_AAAA, 1'b0, 32'h0,         1'b1, 32'h80};
        vecs[9]  = '{1'b1, 32'h80,  1'b1, 32'h0,         1'b1, 32'hAAAA_AAAA, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h40,  1'b0, 32'h2001_0005, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[12] = '{1'b1, 32'h40,  1'b1, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h40,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[14] = '{1'b1, 32'h100, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[15] = '{1'b1, 32'h200, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100};
        vecs[16] = '{1'b0, 32'h200, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100};
        vecs[17] = '{1'b1, 32'h200, 1'b0, 32'h1111_1111, 1'b0, 32'h0,         1'b1, 32'h100};
        vecs[18] = '{1'b1, 32'h200, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[19] = '{1'b1, 32'h200, 1'b0, 32'h2222_2222, 1'b0, 32'h0,         1'b1, 32'h200};
        vecs[20] = '{1'b1, 32'h200, 1'b1, 32'h0,         1'b1, 32'h2222_2222, 1'b0, 32'h0};
        vecs[21] = '{1'b1, 32'h100, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[22] = '{1'b1, 32'h100, 1'b0, 32'h1111_1111, 1'b0, 32'h0,         1'b1, 32'h100};
        vecs[23] = '{1'b1, 32'h100, 1'b1, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 32'h0};
        vecs[24] = '{1'b1, 32'h44,  1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[25] = '{1'b1, 32'h44,  1'b0, 32'h3333_3333, 1'b0, 32'h0,         1'b1, 32'h44};
        vecs[26] = '{1'b1, 32'h100, 1'b1, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 32'h0};
        vecs[27] = '{1'b1, 32'h44,  1'b1, 32'h0,         1'b1, 32'h3333_3333, 1'b0, 32'h0};

        // Reset state: address 0 must not hit an all-zero invalid frame.
        nRST = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h0);
        #2;
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            applyStimulus(vecs[i].ren, vecs[i].addr, vecs[i].iwait, vecs[i].iload);
            #2;
            checkOutput($sformatf("vec%0d", i), vecs[i].expHit, vecs[i].expLoad,
                        vecs[i].expREN, vecs[i].expAddr);
        end

        // Reset in the middle of a miss drops iREN at once and invalidates frames.
        @(negedge CLK);
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
        #2;
        checkOutput("mm_req", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        #1;
        checkOutput("mm_miss", 1'b0, 32'h0, 1'b1, 32'h40);
        nRST = 1'b0;
        #1;
        checkOutput("mm_reset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        applyStimulus(1'b1, 32'h44, 1'b1, 32'h0);
        #2;
        checkOutput("post_rst_44", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        applyStimulus(1'b1, 32'h44, 1'b0, 32'h0000_0005);
        #2;
        checkOutput("post_rst_fill", 1'b0, 32'h0, 1'b1, 32'h44);
        @(negedge CLK);
        applyStimulus(1'b1, 32'h44, 1'b1, 32'h0);
        #2;
        checkOutput("post_rst_hit", 1'b1, 32'h0000_0005, 1'b0, 32'h0);
        @(negedge CLK);
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
        #2;
        checkOutput("post_rst_40", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        #2;
        checkOutput("post_rst_40_miss", 1'b0, 32'h0, 1'b1, 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
